// File: rtl/dac_spi_sequencer.sv
// Sequences both DAC channel words over one SPI link (frame A, frame B, then LDAC); DAC_LDAC_EN enables the LDAC strobe.
// Latency: cs_n falls two edges after the strobe edge; full sequence is 2+64*CLK_DIV+2*CS_GAP(+LDAC_WIDTH) cycles.
// Backpressure: none; a strobe while busy is dropped and flagged on the sticky overrun output.
module dac_spi_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 2,
    parameter int LDAC_WIDTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_sampling,
    input  logic        enableA,
    input  logic        enableB,
    input  logic [11:0] dacA_word,
    input  logic [11:0] dacB_word,
    input  logic        clr_overrun,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        ldac_n,
    output logic        busy,
    output logic        overrun,
    output logic        seq_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FRAME_A,
        GAP_A,
        FRAME_B,
        GAP_B,
        LDAC,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] frame_a;
    logic [15:0] frame_b;
    logic [15:0] shreg;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] cnt;
    logic        sck_q;
    logic        overrun_q;
    logic        in_frame;
    logic        div_end;
    logic        last_fall;
    logic        gap_end;
    logic        ldac_end;
    logic        start_frame;

    assign in_frame    = (state == FRAME_A) || (state == FRAME_B);
    assign div_end     = (div_cnt == 8'(CLK_DIV - 1));
    assign last_fall   = in_frame && div_end && sck_q && (bit_cnt == 4'd15);
    assign gap_end     = (cnt == 16'(CS_GAP - 1));
    assign ldac_end    = (cnt == 16'(LDAC_WIDTH - 1));
    assign start_frame = (state == LOAD) || ((state == GAP_A) && gap_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clk_sampling) state_nxt = LOAD;
            LOAD:    state_nxt = FRAME_A;
            FRAME_A: if (last_fall) state_nxt = GAP_A;
            GAP_A:   if (gap_end) state_nxt = FRAME_B;
            FRAME_B: if (last_fall) state_nxt = GAP_B;
`ifdef DAC_LDAC_EN
            GAP_B:   if (gap_end) state_nxt = LDAC;
`else
            GAP_B:   if (gap_end) state_nxt = DONE;
`endif
            LDAC:    if (ldac_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Words and enables are frozen at the strobe; later input changes never reach the wire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_a <= 16'h0000;
            frame_b <= 16'h0000;
        end else if ((state == IDLE) && clk_sampling) begin
            frame_a <= {1'b0, 1'b0, 1'b1, enableA, dacA_word};
            frame_b <= {1'b1, 1'b0, 1'b1, enableB, dacB_word};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if ((state != IDLE) && clk_sampling) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 16'h0000;
        end else if (state_nxt != state) begin
            cnt <= 16'h0000;
        end else if ((state == GAP_A) || (state == GAP_B) || (state == LDAC)) begin
            cnt <= cnt + 16'h0001;
        end
    end

    // Each SCK half-period is CLK_DIV cycles; mosi shifts on the falling edge so it is
    // stable for a full half-period before the DAC samples it on the rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= 16'h0000;
            div_cnt <= 8'h00;
            bit_cnt <= 4'h0;
            sck_q   <= 1'b0;
        end else if (start_frame) begin
            shreg   <= (state == LOAD) ? frame_a : frame_b;
            div_cnt <= 8'h00;
            bit_cnt <= 4'h0;
            sck_q   <= 1'b0;
        end else if (in_frame) begin
            if (div_end) begin
                div_cnt <= 8'h00;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                end else begin
                    sck_q   <= 1'b0;
                    shreg   <= {shreg[14:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                div_cnt <= div_cnt + 8'h01;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign spi_cs_n = !in_frame;
    assign spi_sck  = sck_q;
    assign spi_mosi = in_frame && shreg[15];
    assign seq_done = (state == DONE);
    assign overrun  = overrun_q;

`ifdef DAC_LDAC_EN
    assign ldac_n = (state != LDAC);
`else
    // Without LDAC the DAC updates each channel on its own cs_n rise.
    assign ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_sequencer.sv
// Bench for dac_spi_sequencer: a CLK_DIV=4 and a CLK_DIV=1 instance checked against a cycle-position model.
module tb_dac_spi_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef DAC_LDAC_EN
    localparam int   LWE   = 2;
    localparam logic LIDLE = 1'b1;
`else
    localparam int   LWE   = 0;
    localparam logic LIDLE = 1'b0;
`endif
    localparam int GAP = 2;
    localparam int LEN0 = 2 + 64 * 4 + 2 * GAP + LWE;
    localparam int LEN1 = 2 + 64 * 1 + 2 * GAP + LWE;
`ifdef DAC_LDAC_EN
    localparam int LIT_LEN0 = 264;
    localparam int LIT_LEN1 = 72;
`else
    localparam int LIT_LEN0 = 262;
    localparam int LIT_LEN1 = 70;
`endif

    logic [1:0]  samp = '0, ena = '0, enb = '0, clr = '0;
    logic [11:0] wa [2];
    logic [11:0] wb [2];
    logic [1:0]  cs_n, sck, mosi, ldac_n, busy, ovr, done;

    dac_spi_sequencer #(.CLK_DIV(4), .CS_GAP(GAP), .LDAC_WIDTH(2)) dut0 (
        .clk(clk), .reset(reset), .clk_sampling(samp[0]), .enableA(ena[0]), .enableB(enb[0]),
        .dacA_word(wa[0]), .dacB_word(wb[0]), .clr_overrun(clr[0]),
        .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .ldac_n(ldac_n[0]),
        .busy(busy[0]), .overrun(ovr[0]), .seq_done(done[0]));

    dac_spi_sequencer #(.CLK_DIV(1), .CS_GAP(GAP), .LDAC_WIDTH(2)) dut1 (
        .clk(clk), .reset(reset), .clk_sampling(samp[1]), .enableA(ena[1]), .enableB(enb[1]),
        .dacA_word(wa[1]), .dacB_word(wb[1]), .clr_overrun(clr[1]),
        .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .ldac_n(ldac_n[1]),
        .busy(busy[1]), .overrun(ovr[1]), .seq_done(done[1]));

    function automatic int pdiv(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int mlen(int i);
        return 2 + 64 * pdiv(i) + 2 * GAP + LWE;
    endfunction

    // Expected {busy, cs_n, sck, mosi, ldac_n, seq_done} k edges after the latching edge.
    function automatic logic [5:0] exp_out(int k, logic [15:0] fa, logic [15:0] fb, int div);
        int f, b0, t, h;
        logic [5:0] r;
        f  = 32 * div;
        b0 = f + GAP + 1;
        r  = {1'b1, 1'b1, 1'b0, 1'b0, LIDLE, 1'b0};
        if (k >= 1 && k <= f) begin
            t = k - 1;
            h = t / div;
            r[4] = 1'b0;
            r[3] = h[0];
            r[2] = fa[15 - h / 2];
        end else if (k >= b0 && k < b0 + f) begin
            t = k - b0;
            h = t / div;
            r[4] = 1'b0;
            r[3] = h[0];
            r[2] = fb[15 - h / 2];
        end else if (k > 2 * f + 2 * GAP && k <= 2 * f + 2 * GAP + LWE) begin
            r[1] = 1'b0;
        end else if (k == 2 * f + 2 * GAP + LWE + 1) begin
            r[0] = 1'b1;
        end
        return r;
    endfunction

    logic        m_act [2];
    int          m_k   [2];
    logic [15:0] m_fa  [2];
    logic [15:0] m_fb  [2];
    logic        m_ovr [2];

    always @(posedge clk or posedge reset) begin
        logic was;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
                m_ovr[i] = 1'b0;
                m_fa[i]  = 16'h0;
                m_fb[i]  = 16'h0;
            end else begin
                was = m_act[i];
                if (was) begin
                    m_k[i] = m_k[i] + 1;
                    if (m_k[i] == mlen(i)) m_act[i] = 1'b0;
                end else if (samp[i]) begin
                    m_act[i] = 1'b1;
                    m_k[i]   = 0;
                    m_fa[i]  = {3'b001, ena[i], wa[i]};
                    m_fb[i]  = {3'b101, enb[i], wb[i]};
                end
                if (was && samp[i]) m_ovr[i] = 1'b1;
                else if (clr[i]) m_ovr[i] = 1'b0;
            end
        end
    end

    task automatic chk(string name, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0] e, g;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                e = m_act[i] ? exp_out(m_k[i], m_fa[i], m_fb[i], pdiv(i))
                             : {1'b0, 1'b1, 1'b0, 1'b0, LIDLE, 1'b0};
                g = {busy[i], cs_n[i], sck[i], mosi[i], ldac_n[i], done[i]};
                checks++;
                if (g !== e) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL outputs dut%0d k=%0d busy,cs,sck,mosi,ldac,done got %b expected %b",
                                 i, m_k[i], g, e);
                end
                chk($sformatf("overrun dut%0d", i), ovr[i], m_ovr[i]);
            end
        end
    end

    // Bus sniffer: rebuilds frames from SCK rises and measures cs_n / busy / ldac windows.
    logic [15:0] fq [$];
    int          cq [$];
    int          bq [$];
    int          lq [$];
    logic [15:0] cap    [2];
    logic        psck   [2];
    int          lowcnt [2];
    int          bcnt   [2];
    int          lcnt   [2];
    int          rises = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                lowcnt[i] = 0;
                bcnt[i]   = 0;
                lcnt[i]   = 0;
                psck[i]   = 1'b0;
                cap[i]    = 16'h0;
            end else begin
                if (sck[i] && !psck[i]) begin
                    cap[i] = {cap[i][14:0], mosi[i]};
                    rises++;
                end
                psck[i] = sck[i];
                if (!cs_n[i]) lowcnt[i]++;
                else if (lowcnt[i] != 0) begin
                    fq.push_back(cap[i]);
                    cq.push_back(lowcnt[i]);
                    lowcnt[i] = 0;
                end
                if (busy[i]) begin
                    bcnt[i]++;
                    if (!ldac_n[i]) lcnt[i]++;
                end else if (bcnt[i] != 0) begin
                    bq.push_back(bcnt[i]);
                    lq.push_back(lcnt[i]);
                    bcnt[i] = 0;
                    lcnt[i] = 0;
                end
            end
        end
    end

    task automatic missing(string name);
        checks++;
        errors++;
        $display("FAIL %s: got nothing expected a value", name);
    endtask

    task automatic strobe(int i, logic [11:0] a, logic [11:0] b, logic ea, logic eb);
        @(posedge clk);
        #2;
        wa[i]   = a;
        wb[i]   = b;
        ena[i]  = ea;
        enb[i]  = eb;
        samp[i] = 1'b1;
        @(posedge clk);
        #2;
        samp[i] = 1'b0;
    endtask

    task automatic wait_idle(int i, int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy[i]) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: still busy after %0d cycles", i, budget);
        end
        @(negedge clk);
    endtask

    task automatic check_seq(string tag, logic [15:0] ea, logic [15:0] eb, int ecs, int ebusy);
        for (int j = 0; j < 2; j++) begin
            if (fq.size() == 0) missing($sformatf("%s frame%0d", tag, j));
            else chk($sformatf("%s frame%0d", tag, j), fq.pop_front(), (j == 0) ? ea : eb);
            if (cq.size() == 0) missing($sformatf("%s cs_low%0d", tag, j));
            else chk($sformatf("%s cs_low%0d", tag, j), cq.pop_front(), ecs);
        end
        if (bq.size() == 0) missing({tag, " busy_len"});
        else chk({tag, " busy_len"}, bq.pop_front(), ebusy);
        if (lq.size() == 0) missing({tag, " ldac_low"});
`ifdef DAC_LDAC_EN
        else chk({tag, " ldac_low"}, lq.pop_front(), 2);
`else
        else chk({tag, " ldac_low"}, lq.pop_front(), ebusy);
`endif
    endtask

    initial begin
        wa[0] = '0; wa[1] = '0; wb[0] = '0; wb[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cs_n", cs_n[0], 1);
        chk("reset sck", sck[0], 0);
        chk("reset ldac_n", ldac_n[0], LIDLE);
        chk("reset busy", busy[0], 0);
        chk("reset overrun", ovr[0], 0);
        @(posedge clk);
        #2 reset = 1'b0;

        repeat (100) @(posedge clk);
        chk("idle sck rises", rises, 0);
        chk("idle frames", fq.size(), 0);
        if (LEN0 != LIT_LEN0 || LEN1 != LIT_LEN1) begin
            checks++;
            errors++;
            $display("FAIL model length: got %0d/%0d expected %0d/%0d", LEN0, LEN1, LIT_LEN0, LIT_LEN1);
        end

        strobe(0, 12'h800, 12'hFFF, 1'b1, 1'b1);
        wait_idle(0, 400);
        check_seq("basic", 16'h3800, 16'hBFFF, 128, LIT_LEN0);

        strobe(0, 12'h123, 12'h000, 1'b0, 1'b1);
        wait_idle(0, 400);
        check_seq("disA", 16'h2123, 16'hB000, 128, LIT_LEN0);

        strobe(0, 12'h456, 12'h789, 1'b1, 1'b1);
        repeat (99) @(posedge clk);
        strobe(0, 12'h555, 12'h0AA, 1'b0, 1'b0);
        wait_idle(0, 400);
        check_seq("overrun_seq", 16'h3456, 16'hB789, 128, LIT_LEN0);
        chk("overrun sticky", ovr[0], 1);
        @(posedge clk);
        #2 clr[0] = 1'b1;
        @(posedge clk);
        #2 clr[0] = 1'b0;
        @(negedge clk);
        chk("overrun cleared", ovr[0], 0);
        strobe(0, 12'h001, 12'h002, 1'b1, 1'b1);
        wait_idle(0, 400);
        check_seq("after_clr", 16'h3001, 16'hB002, 128, LIT_LEN0);
        chk("overrun stays clear", ovr[0], 0);

        strobe(0, 12'hABC, 12'h321, 1'b1, 1'b0);
        repeat (188) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort cs_n", cs_n[0], 1);
        chk("abort sck", sck[0], 0);
        chk("abort mosi", mosi[0], 0);
        chk("abort ldac_n", ldac_n[0], LIDLE);
        chk("abort busy", busy[0], 0);
        chk("abort seq_done", done[0], 0);
        @(posedge clk);
        #2 reset = 1'b0;
        fq.delete();
        cq.delete();
        bq.delete();
        lq.delete();
        strobe(0, 12'hABC, 12'h321, 1'b1, 1'b0);
        wait_idle(0, 400);
        check_seq("post_reset", 16'h3ABC, 16'hA321, 128, LIT_LEN0);

        strobe(1, 12'h0F0, 12'hF0F, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        wa[1]  = 12'h111;
        wb[1]  = 12'h222;
        ena[1] = 1'b0;
        enb[1] = 1'b0;
        wait_idle(1, 200);
        check_seq("div1", 16'h30F0, 16'hBF0F, 32, LIT_LEN1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
